mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single unified cache port between instruction fetch and the load/store unit. It accepts one request at a time, issues it to the cache, waits for the cache response and routes the result back to the winning requester. Data accesses win by default. A starvation counter guarantees forward progress for fetch.

---
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified cache port between instruction fetch
// and the load/store unit. One access is outstanding at a time. Data wins by
// default, and a starvation counter forces a fetch grant after STARVE_LIMIT
// consecutive data grants that were made while fetch was waiting.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  // instruction fetch side
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  // load/store side
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [3:0]            d_strobe,
  input  logic [2:0]            d_load_type,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  // cache port
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_strobe,
  output logic [2:0]            mem_load_type,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT_C    = 4'(STARVE_LIMIT);
  localparam logic [2:0] LT_WORD    = 3'b100;
  localparam logic       OWNER_IF   = 1'b0;
  localparam logic       OWNER_DATA = 1'b1;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_owner;
  logic [3:0]            r_starve_cnt;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [3:0]            r_mem_strobe;
  logic [2:0]            r_mem_load_type;

  logic w_idle;
  logic w_limit_hit;
  logic w_if_win;
  logic w_d_win;
  logic w_resp;

  // Arbitration: only in IDLE; data wins unless fetch has been starved.
  always_comb begin
    w_idle      = (r_state == S_IDLE);
    w_limit_hit = (r_starve_cnt >= LIMIT_C);
    w_if_win    = w_idle && if_req && (!d_req || w_limit_hit);
    w_d_win     = w_idle && d_req && !(if_req && w_limit_hit);
    w_resp      = (r_state == S_WAIT) && mem_rvalid;
  end

  // Next-state logic for the IDLE -> ISSUE -> WAIT access sequence.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (w_if_win || w_d_win) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT:  if (mem_rvalid) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Capture the winning request into the cache-port registers at the grant edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_owner         <= OWNER_IF;
      r_mem_we        <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_mem_strobe    <= '0;
      r_mem_load_type <= '0;
    end else if (w_d_win) begin
      r_owner         <= OWNER_DATA;
      r_mem_we        <= d_we;
      r_mem_addr      <= d_addr;
      r_mem_wdata     <= d_wdata;
      r_mem_strobe    <= d_strobe;
      r_mem_load_type <= d_load_type;
    end else if (w_if_win) begin
      r_owner         <= OWNER_IF;
      r_mem_we        <= 1'b0;
      r_mem_addr      <= if_addr;
      r_mem_strobe    <= 4'b1111;
      r_mem_load_type <= LT_WORD;
    end
  end

  // Starvation counter: counts data grants made while fetch was waiting.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_starve_cnt <= '0;
    end else if (w_if_win) begin
      r_starve_cnt <= '0;
    end else if (w_d_win && if_req && (r_starve_cnt < LIMIT_C)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Outputs: grants, single-cycle access strobe, response routing to owner.
  always_comb begin
    if_gnt        = w_if_win;
    d_gnt         = w_d_win;
    mem_req       = (r_state == S_ISSUE);
    mem_we        = r_mem_we;
    mem_addr      = r_mem_addr;
    mem_wdata     = r_mem_wdata;
    mem_strobe    = r_mem_strobe;
    mem_load_type = r_mem_load_type;
    if_rvalid     = w_resp && (r_owner == OWNER_IF);
    d_rvalid      = w_resp && (r_owner == OWNER_DATA);
    if_rdata      = if_rvalid ? mem_rdata : '0;
    d_rdata       = d_rvalid  ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single transactions with
// hand-computed grants, cache-port fields and responses, followed by
// hand-written sequences for contention, mid-operation reset and a
// spurious cache response.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        if_req;
  logic [9:0]  if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [9:0]  d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_strobe;
  logic [2:0]  d_load_type;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_strobe;
  logic [2:0]  mem_load_type;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH  (10),
    .DATA_WIDTH  (32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_gnt       (if_gnt),
    .if_rvalid    (if_rvalid),
    .if_rdata     (if_rdata),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_strobe     (d_strobe),
    .d_load_type  (d_load_type),
    .d_gnt        (d_gnt),
    .d_rvalid     (d_rvalid),
    .d_rdata      (d_rdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_strobe   (mem_strobe),
    .mem_load_type(mem_load_type),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  // win: 0 = no grant, 1 = fetch, 2 = data. lat: cycles from mem_req to response.
  typedef struct {
    logic        ifr;
    logic        dr;
    logic        we;
    logic [9:0]  ia;
    logic [9:0]  da;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [2:0]  lt;
    logic [31:0] rd;
    int unsigned lat;
    int unsigned win;
    logic [9:0]  e_addr;
    logic        e_we;
    logic [3:0]  e_st;
    logic [2:0]  e_lt;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_gnt"},   32'(if_gnt), 32'd0);
    chk({tag, "_d_gnt"},    32'(d_gnt), 32'd0);
    chk({tag, "_if_rvalid"}, 32'(if_rvalid), 32'd0);
    chk({tag, "_d_rvalid"}, 32'(d_rvalid), 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_d_rdata"},  d_rdata, 32'd0);
    chk({tag, "_mem_req"},  32'(mem_req), 32'd0);
    chk({tag, "_mem_we"},   32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_strobe"}, 32'(mem_strobe), 32'd0);
    chk({tag, "_mem_lt"},   32'(mem_load_type), 32'd0);
  endtask

  // One complete transaction from an idle DUT, ending back in IDLE.
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    if_req = v.ifr; if_addr = v.ia;
    d_req = v.dr; d_we = v.we; d_addr = v.da; d_wdata = v.wd;
    d_strobe = v.st; d_load_type = v.lt;
    #1;
    chk({tag, "_if_gnt"}, 32'(if_gnt), 32'(v.win == 1));
    chk({tag, "_d_gnt"},  32'(d_gnt),  32'(v.win == 2));
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    #1;
    if (v.win == 0) begin
      chk({tag, "_no_mem_req"}, 32'(mem_req), 32'd0);
      return;
    end
    chk({tag, "_mem_req"},  32'(mem_req), 32'd1);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(v.e_addr));
    chk({tag, "_mem_we"},   32'(mem_we), 32'(v.e_we));
    chk({tag, "_mem_strobe"}, 32'(mem_strobe), 32'(v.e_st));
    chk({tag, "_mem_lt"},   32'(mem_load_type), 32'(v.e_lt));
    if (v.win == 2) chk({tag, "_mem_wdata"}, mem_wdata, v.wd);
    for (int unsigned i = 1; i < v.lat; i++) begin
      @(negedge clk); #1;
      chk({tag, "_wait_mem_req"}, 32'(mem_req), 32'd0);
      chk({tag, "_wait_rv"}, 32'({if_rvalid, d_rvalid}), 32'd0);
      chk({tag, "_hold_addr"}, 32'(mem_addr), 32'(v.e_addr));
    end
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = v.rd;
    #1;
    chk({tag, "_if_rvalid"}, 32'(if_rvalid), 32'(v.win == 1));
    chk({tag, "_d_rvalid"},  32'(d_rvalid),  32'(v.win == 2));
    if (v.win == 1) chk({tag, "_if_rdata"}, if_rdata, v.rd);
    if (v.win == 2 && !v.we) chk({tag, "_d_rdata"}, d_rdata, v.rd);
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    chk({tag, "_rv_pulse_end"}, 32'({if_rvalid, d_rvalid}), 32'd0);
  endtask

  function automatic vec_t mk(input logic ifr, dr, we, input logic [9:0] ia, da,
                              input logic [31:0] wd, input logic [3:0] st,
                              input logic [2:0] lt, input logic [31:0] rd,
                              input int unsigned lat, win, input logic [9:0] ea,
                              input logic ew, input logic [3:0] es, input logic [2:0] el);
    vec_t v;
    v.ifr = ifr; v.dr = dr; v.we = we; v.ia = ia; v.da = da; v.wd = wd;
    v.st = st; v.lt = lt; v.rd = rd; v.lat = lat; v.win = win;
    v.e_addr = ea; v.e_we = ew; v.e_st = es; v.e_lt = el;
    return v;
  endfunction

  initial begin
    resetn = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_strobe = '0; d_load_type = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;

    //          ifr dr we ia      da      wd            st       lt      rd            lat win e_addr  e_we e_st     e_lt
    vecs[0] = mk(1, 0, 0, 10'h010, 10'h000, 32'h0,        4'b0000, 3'b000, 32'h00500093, 1, 1, 10'h010, 0, 4'b1111, 3'b100);
    vecs[1] = mk(0, 1, 0, 10'h000, 10'h123, 32'h0,        4'b1111, 3'b010, 32'hCAFEF00D, 2, 2, 10'h123, 0, 4'b1111, 3'b010);
    vecs[2] = mk(0, 1, 1, 10'h000, 10'h3FC, 32'hDEADBEEF, 4'b0011, 3'b000, 32'h12345678, 3, 2, 10'h3FC, 1, 4'b0011, 3'b000);
    // Contention: four data grants build starve_cnt to 4, then fetch is forced.
    vecs[3] = mk(1, 1, 0, 10'h020, 10'h100, 32'h0,        4'b0001, 3'b010, 32'h00000101, 1, 2, 10'h100, 0, 4'b0001, 3'b010);
    vecs[4] = mk(1, 1, 0, 10'h020, 10'h104, 32'h0,        4'b0001, 3'b010, 32'h00000102, 1, 2, 10'h104, 0, 4'b0001, 3'b010);
    vecs[5] = mk(1, 1, 0, 10'h020, 10'h108, 32'h0,        4'b0001, 3'b010, 32'h00000103, 1, 2, 10'h108, 0, 4'b0001, 3'b010);
    vecs[6] = mk(1, 1, 0, 10'h020, 10'h10C, 32'h0,        4'b0001, 3'b010, 32'h00000104, 1, 2, 10'h10C, 0, 4'b0001, 3'b010);
    vecs[7] = mk(1, 1, 0, 10'h020, 10'h110, 32'h0,        4'b0001, 3'b010, 32'h00000013, 2, 1, 10'h020, 0, 4'b1111, 3'b100);
    // Counter was cleared by the fetch grant, so data wins again.
    vecs[8] = mk(1, 1, 0, 10'h024, 10'h114, 32'h0,        4'b0001, 3'b010, 32'h00000105, 1, 2, 10'h114, 0, 4'b0001, 3'b010);
    vecs[9] = mk(0, 0, 0, 10'h000, 10'h000, 32'h0,        4'b0000, 3'b000, 32'h0,        1, 0, 10'h000, 0, 4'b0000, 3'b000);

    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    for (int unsigned k = 0; k < 10; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Reset while waiting for a load response; the late response is dropped.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h2A8; d_strobe = 4'b1111; d_load_type = 3'b010;
    @(negedge clk);
    d_req = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_pre_addr", 32'(mem_addr), 32'h2A8);
    resetn = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst_rel_rv", 32'({if_rvalid, d_rvalid}), 32'd0);
    @(negedge clk); #1;
    chk("rst_late_rv", 32'({if_rvalid, d_rvalid}), 32'd0);
    chk("rst_late_mem_req", 32'(mem_req), 32'd0);
    mem_rvalid = 1'b0; mem_rdata = '0;
    run_vec(vecs[0], "post_rst");

    // Contention with held requests and starve_cnt=0: data at 0, fetch at 3.
    @(negedge clk);
    if_req = 1'b1; if_addr = 10'h040;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h200; d_strobe = 4'b1111; d_load_type = 3'b010;
    #1;
    chk("cont_c0_d_gnt", 32'(d_gnt), 32'd1);
    chk("cont_c0_if_gnt", 32'(if_gnt), 32'd0);
    @(negedge clk);
    d_req = 1'b0;
    #1;
    chk("cont_c1_if_gnt", 32'(if_gnt), 32'd0);
    chk("cont_c1_mem_addr", 32'(mem_addr), 32'h200);
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h0000AAAA;
    #1;
    chk("cont_c2_if_gnt", 32'(if_gnt), 32'd0);
    chk("cont_c2_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("cont_c2_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("cont_c2_d_rdata", d_rdata, 32'h0000AAAA);
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    chk("cont_c3_if_gnt", 32'(if_gnt), 32'd1);
    chk("cont_c3_d_gnt", 32'(d_gnt), 32'd0);
    @(negedge clk);
    if_req = 1'b0;
    #1;
    chk("cont_c4_mem_req", 32'(mem_req), 32'd1);
    chk("cont_c4_mem_addr", 32'(mem_addr), 32'h040);
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h0000BBBB;
    #1;
    chk("cont_c5_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("cont_c5_if_rdata", if_rdata, 32'h0000BBBB);
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0;

    // Spurious cache response while idle: ignored, no state change.
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
    #1;
    chk("spur_rv", 32'({if_rvalid, d_rvalid}), 32'd0);
    chk("spur_rdata", if_rdata | d_rdata, 32'd0);
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    chk("spur_mem_req", 32'(mem_req), 32'd0);
    run_vec(vecs[1], "post_spur");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
